// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key scheduler: FSM states and the
// C4..C5 tone table expressed as half-periods of the 1 MHz system clock.
package piano_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_e;

   localparam int NUM_KEYS = 8;

   localparam logic [15:0] HALF_PERIOD [NUM_KEYS] = '{
      16'd1911, 16'd1703, 16'd1517, 16'd1432,
      16'd1276, 16'd1136, 16'd1012, 16'd956
   };

endpackage

// File: rtl/key_debouncer.sv
// Conditions one raw key: 2-flop synchronizer, stable-level debouncer and a
// single-cycle pulse on each accepted press.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 21
) (
   input  logic iClk,
   input  logic iReset_n,
   input  logic iKey,
   output logic oPress
);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= iKey;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any cycle where the synchronized level agrees with the accepted one
   // restarts the count, so a bounce never accumulates toward a change.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign oPress = press_q;

endmodule

// File: rtl/piano_key_scheduler.sv
// Debounces the key matrix, picks one note per press burst, sequences it as a
// fixed ring window (with a silent gap on retrigger) and drives the buzzer.
module piano_key_scheduler #(
   parameter int NUM_KEYS        = 8,
   parameter int HOLD_CYCLES     = 200000,
   parameter int GAP_CYCLES      = 2000,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 21
) (
   input  logic                iClk,
   input  logic                iReset_n,
   input  logic [NUM_KEYS-1:0] iKeys,
   output logic                oPlay,
   output logic [2:0]          oNoteIdx,
   output logic                oBuzzer,
   output logic                oBusy
);

   import piano_pkg::*;

   logic [NUM_KEYS-1:0] press;
   logic                anyPress;
   logic [2:0]          winner;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic [CNT_W-1:0]    gap_q, gap_d;
   logic [2:0]          note_q, note_d;
   logic [2:0]          pend_q, pend_d;
   logic [15:0]         tone_q, tone_d;
   logic                buzz_q, buzz_d;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : gKey
      key_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) uDebouncer (
         .iClk     (iClk),
         .iReset_n (iReset_n),
         .iKey     (iKeys[g]),
         .oPress   (press[g])
      );
   end

   // Scanning from the top down leaves the lowest pressed index as winner.
   always_comb begin
      winner   = '0;
      anyPress = 1'b0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) begin
            winner   = 3'(i);
            anyPress = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         gap_q   <= '0;
         note_q  <= '0;
         pend_q  <= '0;
         tone_q  <= '0;
         buzz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         note_q  <= note_d;
         pend_q  <= pend_d;
         tone_q  <= tone_d;
         buzz_q  <= buzz_d;
      end
   end

   // A new press always beats window expiry; during the gap it only
   // replaces the pending note and leaves the gap timer running.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      note_d  = note_q;
      pend_d  = pend_q;
      tone_d  = '0;
      buzz_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (anyPress) begin
               state_d = PLAY;
               note_d  = winner;
               hold_d  = '0;
            end
         end
         PLAY: begin
            if (anyPress) begin
               state_d = GAP;
               pend_d  = winner;
               gap_d   = '0;
            end else if (hold_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         GAP: begin
            if (anyPress) begin
               pend_d = winner;
            end
            if (gap_q == CNT_W'(GAP_CYCLES - 1)) begin
               state_d = PLAY;
               note_d  = anyPress ? winner : pend_q;
               hold_d  = '0;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The tone only runs while staying in PLAY, so every entry starts from zero.
      if ((state_q == PLAY) && (state_d == PLAY)) begin
         if (tone_q == HALF_PERIOD[note_q] - 16'd1) begin
            tone_d = '0;
            buzz_d = ~buzz_q;
         end else begin
            tone_d = tone_q + 16'd1;
            buzz_d = buzz_q;
         end
      end
   end

   assign oPlay    = (state_q == PLAY);
   assign oBusy    = (state_q != IDLE);
   assign oNoteIdx = note_q;
   assign oBuzzer  = buzz_q;

endmodule

// File: tb/tb_piano_key_scheduler.sv
// Self-checking bench: two schedulers (short and long ring windows) share one
// key stimulus and are compared every cycle against a behavioural model.
module tb_piano_key_scheduler;

   localparam int GAP = 10;
   localparam int DEB = 4;

   logic       iClk;
   logic       iReset_n;
   logic [7:0] iKeys;

   logic       playS, buzzS, busyS;
   logic [2:0] noteS;
   logic       playL, buzzL, busyL;
   logic [2:0] noteL;

   int nCompared   = 0;
   int nMismatched = 0;
   int cycle       = 0;

   int hp [8]      = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};
   int holdLen [2] = '{100, 3000};

   // Model: 0 = idle, 1 = sounding, 2 = silent gap
   int mState [2], mHoldLeft [2], mGapLeft [2], mNote [2], mPend [2], mElapsed [2];
   bit [7:0] s1, s2, lvl, evtMask;
   int run [8];

   piano_key_scheduler #(
      .NUM_KEYS(8), .HOLD_CYCLES(100), .GAP_CYCLES(GAP), .DEBOUNCE_CYCLES(DEB), .CNT_W(21)
   ) dutShort (
      .iClk(iClk), .iReset_n(iReset_n), .iKeys(iKeys),
      .oPlay(playS), .oNoteIdx(noteS), .oBuzzer(buzzS), .oBusy(busyS)
   );

   piano_key_scheduler #(
      .NUM_KEYS(8), .HOLD_CYCLES(3000), .GAP_CYCLES(GAP), .DEBOUNCE_CYCLES(DEB), .CNT_W(21)
   ) dutLong (
      .iClk(iClk), .iReset_n(iReset_n), .iKeys(iKeys),
      .oPlay(playL), .oNoteIdx(noteL), .oBuzzer(buzzL), .oBusy(busyL)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      nCompared++;
      if (observed != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
      end
   endtask

   function automatic int expBuzz(input int j);
      if (mState[j] != 1) return 0;
      return (mElapsed[j] / hp[mNote[j]]) % 2;
   endfunction

   // One clock edge of the reference behaviour; presses accepted at this edge
   // act on the scheduler one edge later.
   task automatic modelStep(input logic [7:0] k, input logic rstn);
      bit [7:0] newMask;
      bit       used;
      bit       evt;
      int       w;
      if (!rstn) begin
         s1 = '0; s2 = '0; lvl = '0; evtMask = '0;
         for (int i = 0; i < 8; i++) run[i] = 0;
         for (int j = 0; j < 2; j++) begin
            mState[j] = 0; mNote[j] = 0; mPend[j] = 0; mElapsed[j] = 0;
         end
         return;
      end
      evt = (evtMask != 0);
      w   = 0;
      for (int i = 7; i >= 0; i--) if (evtMask[i]) w = i;
      for (int j = 0; j < 2; j++) begin
         case (mState[j])
            0: begin
               if (evt) begin
                  mState[j] = 1; mNote[j] = w; mHoldLeft[j] = holdLen[j]; mElapsed[j] = 0;
               end
            end
            1: begin
               if (evt) begin
                  mState[j] = 2; mPend[j] = w; mGapLeft[j] = GAP;
               end else begin
                  mHoldLeft[j]--;
                  mElapsed[j]++;
                  if (mHoldLeft[j] == 0) mState[j] = 0;
               end
            end
            2: begin
               if (evt) mPend[j] = w;
               mGapLeft[j]--;
               if (mGapLeft[j] == 0) begin
                  mState[j] = 1; mNote[j] = mPend[j]; mHoldLeft[j] = holdLen[j]; mElapsed[j] = 0;
               end
            end
            default: ;
         endcase
      end
      newMask = '0;
      for (int i = 0; i < 8; i++) begin
         used  = s2[i];
         s2[i] = s1[i];
         s1[i] = k[i];
         if (used != lvl[i]) begin
            run[i]++;
            if (run[i] == DEB) begin
               lvl[i] = used;
               run[i] = 0;
               if (used) newMask[i] = 1'b1;
            end
         end else begin
            run[i] = 0;
         end
      end
      evtMask = newMask;
   endtask

   task automatic applyStimulus(input logic [7:0] k, input logic rstn);
      @(negedge iClk);
      iKeys    = k;
      iReset_n = rstn;
      @(posedge iClk);
      modelStep(k, rstn);
      cycle++;
      #1;
      checkOutput("short.play", int'(playS), int'(mState[0] == 1));
      checkOutput("short.busy", int'(busyS), int'(mState[0] != 0));
      checkOutput("short.note", int'(noteS), mNote[0]);
      checkOutput("short.buzz", int'(buzzS), expBuzz(0));
      checkOutput("long.play",  int'(playL), int'(mState[1] == 1));
      checkOutput("long.busy",  int'(busyL), int'(mState[1] != 0));
      checkOutput("long.note",  int'(noteL), mNote[1]);
      checkOutput("long.buzz",  int'(buzzL), expBuzz(1));
   endtask

   initial begin
      int       playCnt, toggles, t1, t2, seen6, r, dur;
      logic     prevBuzzL;
      logic [7:0] k;
      bit       bounce [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

      iKeys    = '0;
      iReset_n = 1'b0;

      // Quiet after reset
      for (int n = 0; n < 3; n++) applyStimulus(8'h00, 1'b0);
      for (int n = 0; n < 50; n++) applyStimulus(8'h00, 1'b1);

      // Clean press of key 5: window length and tone period
      playCnt = 0; toggles = 0; t1 = 0; t2 = 0; prevBuzzL = 1'b0;
      for (int n = 0; n < 3110; n++) begin
         applyStimulus((n < 10) ? 8'h20 : 8'h00, 1'b1);
         if (playS) playCnt++;
         if (buzzL != prevBuzzL) begin
            toggles++;
            if (toggles == 1) t1 = cycle;
            if (toggles == 2) t2 = cycle;
         end
         prevBuzzL = buzzL;
      end
      checkOutput("key5.window", playCnt, 100);
      checkOutput("key5.toggles", toggles, 2);
      checkOutput("key5.period", 2 * (t2 - t1), 2272);

      // Keys 2 and 6 together: only key 2 plays
      seen6 = 0;
      for (int n = 0; n < 130; n++) begin
         applyStimulus((n < 10) ? 8'h44 : 8'h00, 1'b1);
         if (playS && noteS == 3'd6) seen6 = 1;
      end
      checkOutput("k26.no6", seen6, 0);

      // Key 1 bouncing then stable
      for (int n = 0; n < 8; n++) applyStimulus({6'b0, bounce[n / 2], 1'b0}, 1'b1);
      for (int n = 0; n < 20; n++) applyStimulus(8'h02, 1'b1);
      for (int n = 0; n < 110; n++) applyStimulus(8'h00, 1'b1);

      // Retrigger with key 7, then key 3 overrides during the gap
      for (int n = 0; n < 200; n++) begin
         if (n < 10)       k = 8'h01;
         else if (n < 50)  k = 8'h00;
         else if (n < 54)  k = 8'h80;
         else if (n < 70)  k = 8'h88;
         else              k = 8'h00;
         applyStimulus(k, 1'b1);
      end

      // Reset mid-note while key 4 is held
      for (int n = 0; n < 80; n++) begin
         applyStimulus(8'h10, (n == 46) ? 1'b0 : 1'b1);
         if (n == 46) begin
            checkOutput("rst.play", int'(playS), 0);
            checkOutput("rst.buzz", int'(buzzS), 0);
            checkOutput("rst.busy", int'(busyS), 0);
            checkOutput("rst.note", int'(noteS), 0);
         end
      end
      for (int n = 0; n < 150; n++) applyStimulus(8'h00, 1'b1);

      // Randomized key activity with occasional resets
      for (int s = 0; s < 400; s++) begin
         r = int'($urandom_range(0, 19));
         if (r < 8)       k = 8'h00;
         else if (r < 16) k = 8'(1 << $urandom_range(0, 7));
         else             k = 8'($urandom);
         dur = int'($urandom_range(1, 30));
         for (int d = 0; d < dur; d++) applyStimulus(k, !(r == 19 && d == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
